// File: rtl/hamming_write_encoder.sv
// hamming_write_encoder
//   Write-side Hamming(12,8) SEC encoder feeding the memory write port.
//   Request handshake (in_*) -> combinational encode -> output register with a
//   one-entry skid register behind it, giving full throughput and keeping
//   out_* stable while the memory stalls.
//   Optional feature macro: ERR_INJECT_EN adds inj_en/inj_pos, which invert
//   one codeword bit of an accepted word (for exercising the decoder's SEC).
module hamming_write_encoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [7:0]            in_data,
`ifdef ERR_INJECT_EN
    input  logic                  inj_en,
    input  logic [3:0]            inj_pos,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [11:0]           out_code,
    output logic [CNT_WIDTH-1:0]  enc_count
);

    // Codeword layout (index = Hamming position - 1):
    //   c0=p1 c1=p2 c2=d0 c3=p4 c4=d1 c5=d2 c6=d3 c7=p8 c8..c11=d4..d7
    function automatic logic [11:0] hamming_encode(input logic [7:0] d);
        logic [11:0] c;
        c     = '0;
        c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[2]  = d[0];
        c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[4]  = d[1];
        c[5]  = d[2];
        c[6]  = d[3];
        c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
        c[8]  = d[4];
        c[9]  = d[5];
        c[10] = d[6];
        c[11] = d[7];
        return c;
    endfunction

    // Output register
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
    logic [11:0]           out_code_q,  out_code_d;

    // Skid register
    logic                  skid_valid_q, skid_valid_d;
    logic [ADDR_WIDTH-1:0] skid_addr_q,  skid_addr_d;
    logic [11:0]           skid_code_q,  skid_code_d;

    // Handed-off word counter
    logic [CNT_WIDTH-1:0]  enc_count_q, enc_count_d;

    logic [11:0] inj_mask;
    logic [11:0] enc_code;
    logic        accept;
    logic        send;
    logic        out_load;

`ifdef ERR_INJECT_EN
    // One-hot flip mask for positions 1..12; other positions leave the word clean
    always_comb begin
        inj_mask = '0;
        if (inj_en && (inj_pos >= 4'd1) && (inj_pos <= 4'd12)) begin
            inj_mask[inj_pos - 4'd1] = 1'b1;
        end
    end
`else
    assign inj_mask = '0;
`endif

    assign enc_code = hamming_encode(in_data) ^ inj_mask;

    // Skid occupancy alone decides readiness; reset forces it low so nothing
    // can complete a handshake during the reset cycle.
    assign in_ready = ~skid_valid_q & ~rst;

    assign accept   = in_valid & in_ready;
    assign send     = out_valid_q & out_ready;
    assign out_load = ~out_valid_q | out_ready;

    // Next-state for output/skid registers and the counter
    always_comb begin
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_code_d   = out_code_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_code_d  = skid_code_q;
        enc_count_d  = enc_count_q + {{(CNT_WIDTH-1){1'b0}}, send};

        if (out_load) begin
            if (skid_valid_q) begin
                // in_ready is low whenever the skid is full, so no accept here
                out_valid_d  = 1'b1;
                out_addr_d   = skid_addr_q;
                out_code_d   = skid_code_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_addr_d   = in_addr;
                out_code_d   = enc_code;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            // Output is held by the consumer: park the new word in the skid
            skid_valid_d = 1'b1;
            skid_addr_d  = in_addr;
            skid_code_d  = enc_code;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_code_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_code_q  <= '0;
            enc_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_code_q   <= out_code_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_code_q  <= skid_code_d;
            enc_count_q  <= enc_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_code  = out_code_q;
    assign enc_count = enc_count_q;

endmodule

// File: tb/tb_hamming_write_encoder.sv
// tb_hamming_write_encoder
//   Directed bench for hamming_write_encoder. Inputs are driven 1 time unit
//   after the rising edge; outputs are sampled there or on the falling edge.
module tb_hamming_write_encoder;

    localparam int ADDR_WIDTH = 4;
    localparam int CNT_WIDTH  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [7:0]            in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [11:0]           out_code;
    logic [CNT_WIDTH-1:0]  enc_count;
`ifdef ERR_INJECT_EN
    logic                  inj_en;
    logic [3:0]            inj_pos;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    always #5 clk = ~clk;

    hamming_write_encoder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
`ifdef ERR_INJECT_EN
        .inj_en   (inj_en),
        .inj_pos  (inj_pos),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_code (out_code),
        .enc_count(enc_count)
    );

    // Reference encoder built from Hamming positions rather than fixed equations
    function automatic logic [11:0] ref_encode(input logic [7:0] d);
        logic [11:0] c;
        int unsigned k;
        logic par;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++) begin
                if (((pos & p) != 0) && (pos != p)) par = par ^ c[pos-1];
            end
            c[p-1] = par;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; out_ready = 1'b1;
`ifdef ERR_INJECT_EN
        inj_en = 1'b0; inj_pos = '0;
`endif
        tick(); tick(); tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++;
        if (out_code !== 12'h000) begin miscompares++; $display("FAIL reset_out_code got %h want 000", out_code); end
        vectors++;
        if (out_addr !== 4'h0) begin miscompares++; $display("FAIL reset_out_addr got %h want 0", out_addr); end
        vectors++;
        if (enc_count !== 16'd0) begin miscompares++; $display("FAIL reset_enc_count got %0d want 0", enc_count); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_during got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; in_addr = 4'd3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
        vectors++;
        if (out_code !== 12'hA27) begin miscompares++; $display("FAIL single_code got %h want a27", out_code); end
        vectors++;
        if (out_addr !== 4'd3) begin miscompares++; $display("FAIL single_addr got %h want 3", out_addr); end
        tick();
        vectors++;
        if (enc_count !== 16'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", enc_count); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h00; in_addr = 4'd1;
        tick();
        in_data = 8'hFF; in_addr = 4'd2;
        vectors++;
        if (out_valid !== 1'b1 || out_code !== 12'h000 || out_addr !== 4'd1) begin
            miscompares++; $display("FAIL b2b_first got v=%b %h@%h want v=1 000@1", out_valid, out_code, out_addr);
        end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready1 got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_code !== 12'hF77 || out_addr !== 4'd2) begin
            miscompares++; $display("FAIL b2b_second got v=%b %h@%h want v=1 f77@2", out_valid, out_code, out_addr);
        end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready2 got %b want 1", in_ready); end
        tick();
        vectors++;
        if (enc_count !== 16'd3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", enc_count); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h12; in_addr = 4'd1;
        tick();
        in_data = 8'h34; in_addr = 4'd2;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_first got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_full got %b want 0", in_ready); end
        vectors++;
        if (out_code !== ref_encode(8'h12) || out_addr !== 4'd1) begin
            miscompares++; $display("FAIL stall_hold1 got %h@%h want %h@1", out_code, out_addr, ref_encode(8'h12));
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_code !== ref_encode(8'h12)) begin
            miscompares++; $display("FAIL stall_hold2 got v=%b %h want v=1 %h", out_valid, out_code, ref_encode(8'h12));
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_code !== ref_encode(8'h34) || out_addr !== 4'd2) begin
            miscompares++; $display("FAIL stall_second got v=%b %h@%h want v=1 %h@2", out_valid, out_code, out_addr, ref_encode(8'h34));
        end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_release got %b want 1", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || enc_count !== 16'd5) begin
            miscompares++; $display("FAIL stall_drain got v=%b cnt=%0d want v=0 cnt=5", out_valid, enc_count);
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] exp_q[$];
        logic [15:0] exp;
        logic [CNT_WIDTH-1:0] start_cnt;
        int idx;
        int cyc;
        logic acc;
        logic snd;
        start_cnt = enc_count;
        idx = 0;
        cyc = 0;
        in_valid = 1'b1; in_data = 8'h00; in_addr = 4'h0; out_ready = 1'($urandom_range(0, 1));
        while ((idx < 256 || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            snd = out_valid & out_ready;
            if (snd) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL exh_spurious got %h@%h want no word", out_code, out_addr);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_addr, out_code} !== exp[15:0]) begin
                        miscompares++; $display("FAIL exh_word got %h@%h want %h@%h", out_code, out_addr, exp[11:0], exp[15:12]);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back({in_addr, ref_encode(in_data)});
                idx++;
            end
            tick();
            cyc++;
            in_valid = (idx < 256);
            in_data = idx[7:0];
            in_addr = idx[3:0];
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (cyc >= 3000) begin miscompares++; $display("FAIL exh_timeout got %0d cycles want < 3000", cyc); end
        vectors++;
        if (16'(enc_count - start_cnt) !== 16'd256) begin
            miscompares++; $display("FAIL exh_count got %0d want 256", 16'(enc_count - start_cnt));
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; in_addr = 4'd5;
        tick();
        in_data = 8'h22; in_addr = 4'd6;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL mid_full got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || enc_count !== 16'd0) begin
            miscompares++; $display("FAIL mid_reset got v=%b cnt=%0d want v=0 cnt=0", out_valid, enc_count);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale got v=%b code=%h want v=0", out_valid, out_code); end
        end
        vectors++;
        if (enc_count !== 16'd0) begin miscompares++; $display("FAIL mid_count got %0d want 0", enc_count); end
    endtask

`ifdef ERR_INJECT_EN
    task automatic test_inject();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hA5; in_addr = 4'd7; inj_en = 1'b1; inj_pos = 4'd5;
        tick();
        inj_pos = 4'd0;
        vectors++;
        if (out_code !== 12'hA37) begin miscompares++; $display("FAIL inj_pos5 got %h want a37", out_code); end
        tick();
        inj_pos = 4'd13;
        vectors++;
        if (out_code !== 12'hA27) begin miscompares++; $display("FAIL inj_pos0 got %h want a27", out_code); end
        tick();
        inj_pos = 4'd12;
        vectors++;
        if (out_code !== 12'hA27) begin miscompares++; $display("FAIL inj_pos13 got %h want a27", out_code); end
        tick();
        in_valid = 1'b0; inj_en = 1'b0;
        vectors++;
        if (out_code !== 12'h227) begin miscompares++; $display("FAIL inj_pos12 got %h want 227", out_code); end
        tick();
        vectors++;
        if (enc_count !== 16'd4) begin miscompares++; $display("FAIL inj_count got %0d want 4", enc_count); end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_exhaustive();
        test_reset_midflight();
`ifdef ERR_INJECT_EN
        test_inject();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
